// File: rtl/z16_io_pkg.sv
// Shared types and constants for the Z16 board I/O conditioners.
package z16_io_pkg;

  typedef enum logic [1:0] {
    UP        = 2'd0,
    WAIT_DOWN = 2'd1,
    DOWN      = 2'd2,
    WAIT_UP   = 2'd3
  } btn_state_t;

  localparam int C_BTN_DEBOUNCE_27MHZ = 270000;
  localparam int C_BTN_COUNT_W        = 8;

endpackage

// File: rtl/z16_sync2.sv
// Two-flop synchronizer for an asynchronous pin, with a selectable reset level.
module z16_sync2 #(
  parameter logic P_RESET_VALUE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      meta_reg <= P_RESET_VALUE;
      sync_reg <= P_RESET_VALUE;
    end else begin
      meta_reg <= i_d;
      sync_reg <= meta_reg;
    end
  end

  assign o_q = sync_reg;

endmodule

// File: rtl/z16_button_input.sv
// Push-button conditioner: synchronize, debounce, and expose a clean level,
// press/release pulses, a CPU-acknowledged pending flag and a press counter.
module z16_button_input
  import z16_io_pkg::*;
#(
  parameter int P_DEBOUNCE_CYCLES = C_BTN_DEBOUNCE_27MHZ,
  parameter bit P_ACTIVE_LOW      = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_button,
  input  logic                     i_ack,
  output logic                     o_level,
  output logic                     o_press,
  output logic                     o_release,
  output logic                     o_pending,
  output logic [C_BTN_COUNT_W-1:0] o_count
);

  localparam int CNT_W = $clog2(P_DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_DEBOUNCE_CYCLES - 1);

  logic pin_pressed;
  logic s;

  assign pin_pressed = i_button ^ P_ACTIVE_LOW;

  // Reset value 0 is the released level, so a reset never fakes a press.
  z16_sync2 #(
    .P_RESET_VALUE(1'b0)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (pin_pressed),
    .o_q   (s)
  );

  btn_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic                     level_reg, level_next;
  logic                     press_reg, press_next;
  logic                     release_reg, release_next;
  logic                     pending_reg, pending_next;
  logic [C_BTN_COUNT_W-1:0] count_reg, count_next;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg <= UP;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      UP: begin
        if (s) begin
          state_next = WAIT_DOWN;
          cnt_next   = '0;
        end
      end
      WAIT_DOWN: begin
        if (!s) begin
          state_next = UP;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = DOWN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DOWN: begin
        if (!s) begin
          state_next = WAIT_UP;
          cnt_next   = '0;
        end
      end
      WAIT_UP: begin
        if (s) begin
          state_next = DOWN;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = UP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = UP;
        cnt_next   = '0;
      end
    endcase
  end

  // Pulses are edges of the registered level, so they can never overlap.
  always_comb begin
    level_next   = (state_reg == DOWN) || (state_reg == WAIT_UP);
    press_next   = level_next & ~level_reg;
    release_next = ~level_next & level_reg;
    pending_next = press_next | (pending_reg & ~i_ack);
    count_next   = count_reg + C_BTN_COUNT_W'(press_next);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      pending_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      pending_reg <= pending_next;
      count_reg   <= count_next;
    end
  end

  assign o_level   = level_reg;
  assign o_press   = press_reg;
  assign o_release = release_reg;
  assign o_pending = pending_reg;
  assign o_count   = count_reg;

endmodule

// File: tb/tb_z16_button_input.sv
// Bench for z16_button_input with an 8-cycle debounce and an active-low pin.
module tb_z16_button_input;

  localparam int N   = 8;
  localparam int LAT = N + 4;  // drive negedge -> negedge showing the pulse

  localparam int K_NONE  = 0;
  localparam int K_PRESS = 1;
  localparam int K_REL   = 2;

  logic       clk;
  logic       rst;
  logic       button;
  logic       ack;
  logic       level;
  logic       press;
  logic       release_p;
  logic       pending;
  logic [7:0] count;

  z16_button_input #(
    .P_DEBOUNCE_CYCLES(N),
    .P_ACTIVE_LOW     (1'b1)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_button  (button),
    .i_ack     (ack),
    .o_level   (level),
    .o_press   (press),
    .o_release (release_p),
    .o_pending (pending),
    .o_count   (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    int         cyc;
    logic       level;
    logic       pending;
    logic [7:0] count;
  } exp_t;

  typedef struct {
    logic       pressed;
    int         hold;
    int         ack_at;
    int         pulse;
    logic       exp_level;
    logic       exp_pending;
    logic [7:0] exp_count;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int at, input logic lvl, input logic pnd,
                      input logic [7:0] cnt);
    exp_t e;
    e.kind = kind; e.cyc = at; e.level = lvl; e.pending = pnd; e.count = cnt;
    sb.push_back(e);
  endtask

  // Compare any pulse on the outputs against the head of the scoreboard.
  task automatic monitor();
    int kind;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_pulse kind=%0d due_cycle=%0d now=%0d", sb[0].kind, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (press || release_p) begin
      checks++;
      kind = press ? K_PRESS : K_REL;
      if (press && release_p) begin
        errors++;
        $display("FAIL pulse_overlap press=1 release=1 required=one_of cycle=%0d", cyc);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse kind=%0d cycle=%0d required=no_pulse", kind, cyc);
      end else if (sb[0].cyc != cyc || sb[0].kind != kind || level !== sb[0].level ||
                   pending !== sb[0].pending || count !== sb[0].count) begin
        errors++;
        $display("FAIL pulse kind=%0d cyc=%0d lvl=%0b pnd=%0b cnt=%0d required kind=%0d cyc=%0d lvl=%0b pnd=%0b cnt=%0d",
                 kind, cyc, level, pending, count,
                 sb[0].kind, sb[0].cyc, sb[0].level, sb[0].pending, sb[0].count);
        if (sb[0].cyc <= cyc) void'(sb.pop_front());
      end else begin
        $display("pulse kind=%0d cycle=%0d count=%0d ok", kind, cyc, count);
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int start;
    start  = cyc;
    button = v.pressed ? 1'b0 : 1'b1;
    if (v.pulse != K_NONE)
      push(v.pulse, start + LAT, v.pulse == K_PRESS, v.exp_pending, v.exp_count);
    for (int i = 0; i < v.hold; i++) begin
      ack = (i == v.ack_at);
      tick();
    end
    ack = 1'b0;
    $display("vec %0d pressed=%0b hold=%0d ack_at=%0d -> level=%0b pending=%0b count=%0d",
             idx, v.pressed, v.hold, v.ack_at, level, pending, count);
    chk($sformatf("vec%0d_level", idx), 32'(level), 32'(v.exp_level));
    chk($sformatf("vec%0d_pending", idx), 32'(pending), 32'(v.exp_pending));
    chk($sformatf("vec%0d_count", idx), 32'(count), 32'(v.exp_count));
  endtask

  initial begin
    int start;

    vecs[0]  = '{1'b1, 16, -1, K_PRESS, 1'b1, 1'b1, 8'd1};  // clean press
    vecs[1]  = '{1'b0, 16, -1, K_REL,   1'b0, 1'b1, 8'd1};  // release keeps pending
    vecs[2]  = '{1'b1, 16, 11, K_PRESS, 1'b1, 1'b1, 8'd2};  // ack on acceptance edge
    vecs[3]  = '{1'b0, 16, -1, K_REL,   1'b0, 1'b1, 8'd2};
    vecs[4]  = '{1'b0, 4,   1, K_NONE,  1'b0, 1'b0, 8'd2};  // lone ack clears
    vecs[5]  = '{1'b0, 3,   0, K_NONE,  1'b0, 1'b0, 8'd2};  // ack while idle
    vecs[6]  = '{1'b1, 5,  -1, K_NONE,  1'b0, 1'b0, 8'd2};  // bounce low 5
    vecs[7]  = '{1'b0, 2,  -1, K_NONE,  1'b0, 1'b0, 8'd2};  // bounce high 2
    vecs[8]  = '{1'b1, 16, -1, K_PRESS, 1'b1, 1'b1, 8'd3};  // settles pressed
    vecs[9]  = '{1'b0, 3,  -1, K_NONE,  1'b1, 1'b1, 8'd3};  // short release glitch
    vecs[10] = '{1'b1, 6,  -1, K_NONE,  1'b1, 1'b1, 8'd3};
    vecs[11] = '{1'b0, 16, -1, K_REL,   1'b0, 1'b1, 8'd3};

    rst    = 1'b0;
    button = 1'b1;
    ack    = 1'b0;
    tick();
    tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_press", 32'(press), 32'd0);
    chk("rst_release", 32'(release_p), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b1;
    tick();
    tick();

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset while WAIT_DOWN holds cnt=5, pin kept pressed throughout.
    start  = cyc;
    button = 1'b0;
    repeat (8) tick();
    rst = 1'b0;
    #1;
    $display("reset mid-debounce at cycle %0d -> level=%0b pending=%0b count=%0d",
             cyc, level, pending, count);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_press", 32'(press), 32'd0);
    chk("midrst_pending", 32'(pending), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    tick();
    tick();
    rst   = 1'b1;
    start = cyc;
    push(K_PRESS, start + LAT, 1'b1, 1'b1, 8'd1);
    repeat (16) tick();
    chk("postrst_level", 32'(level), 32'd1);
    chk("postrst_count", 32'(count), 32'd1);

    // Fresh start, then 256 accepted presses must wrap the counter to 0.
    rst    = 1'b0;
    button = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    for (int k = 0; k < 256; k++) begin
      start  = cyc;
      button = 1'b0;
      push(K_PRESS, start + LAT, 1'b1, 1'b1, 8'(k + 1));
      repeat (14) tick();
      start  = cyc;
      button = 1'b1;
      push(K_REL, start + LAT, 1'b0, 1'b1, 8'(k + 1));
      repeat (14) tick();
    end
    $display("wrap done -> count=%0d pending=%0b", count, pending);
    chk("wrap_count", 32'(count), 32'd0);
    chk("wrap_pending", 32'(pending), 32'd1);

    repeat (4) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
